// File: rtl/video_timing_decoder_if.sv
// Video timing bundle: raw sync/de from the source, recovered position and
// measured geometry back from the decoder.
interface video_timing_decoder_if;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       pix_valid;
  logic       line_start;
  logic       frame_start;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic [9:0] h_active;
  logic [9:0] v_active;
  logic       locked;

  modport master (
    output hsync, vsync, de,
    input  sx, sy, pix_valid, line_start, frame_start,
    input  h_total, v_total, h_active, v_active, locked
  );

  modport slave (
    input  hsync, vsync, de,
    output sx, sy, pix_valid, line_start, frame_start,
    output h_total, v_total, h_active, v_active, locked
  );
endinterface

// File: rtl/video_timing_decoder.sv
// Video timing decoder: recovers active-pixel coordinates from hsync/vsync/de,
// measures line and frame geometry, and reports lock against expected timing.
module video_timing_decoder #(
  parameter int H_TOTAL_EXP  = 800,
  parameter int V_TOTAL_EXP  = 525,
  parameter int H_ACTIVE_EXP = 640,
  parameter int V_ACTIVE_EXP = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix,
  video_timing_decoder_if.slave vid
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam int         WD_LIMIT = 2 * H_TOTAL_EXP;
  localparam int         WD_W     = $clog2(WD_LIMIT + 1);
  localparam int         MC_W     = $clog2(LOCK_FRAMES + 1);

  // Saturating increment shared by every measurement counter.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  logic hsync_s1, hsync_s2;
  logic vsync_s1, vsync_s2;
  logic de_s1, de_s2;
  logic hs_fall, vs_fall, de_rise, de_fall;

  logic [9:0] sx, sy;
  logic       pix_valid, line_start, frame_start;

  logic [9:0] line_cnt, de_cnt, hs_cnt, de_line_cnt;
  logic [9:0] h_total, v_total, h_active, v_active;
  logic [9:0] h_total_nxt, v_total_nxt, h_active_nxt, v_active_nxt;
  logic       frame_match;

  logic [WD_W-1:0] wd;
  logic            wd_trip;

  logic [1:0]      state, state_nxt;
  logic [MC_W-1:0] match_cnt, match_nxt, match_inc;
  logic            locked;

  // Two-stage input pipeline; syncs idle high (negative polarity), de idles low.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hsync_s1 <= 1'b1;
      hsync_s2 <= 1'b1;
      vsync_s1 <= 1'b1;
      vsync_s2 <= 1'b1;
      de_s1    <= 1'b0;
      de_s2    <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2 receives the old s1, giving a real two-stage pipe.
      hsync_s1 <= vid.hsync;
      hsync_s2 <= hsync_s1;
      vsync_s1 <= vid.vsync;
      vsync_s2 <= vsync_s1;
      de_s1    <= vid.de;
      de_s2    <= de_s1;
    end
  end

  assign hs_fall = hsync_s2 & ~hsync_s1;
  assign vs_fall = vsync_s2 & ~vsync_s1;
  assign de_rise = ~de_s2 & de_s1;
  assign de_fall = de_s2 & ~de_s1;

  // Pixel position recovery and one-cycle line/frame start pulses.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx          <= '0;
      sy          <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= de_s1;
      line_start  <= hs_fall;
      frame_start <= vs_fall;
      if (de_rise)     sx <= '0;
      else if (de_s1)  sx <= sx + 10'd1;
      if (vs_fall)      sy <= '0;
      else if (de_fall) sy <= sy + 10'd1;
    end
  end

  // Values the measurement outputs take after this edge; a sync edge that
  // coincides with vs_fall is folded in before the frame counts latch.
  // line_cnt restarts at 1 after hs_fall, so at the next hs_fall it already
  // equals the clocks elapsed up to and including the current cycle.
  assign h_total_nxt  = hs_fall ? line_cnt : h_total;
  assign h_active_nxt = de_fall ? de_cnt : h_active;
  assign v_total_nxt  = vs_fall ? (hs_fall ? sat_inc(hs_cnt) : hs_cnt) : v_total;
  assign v_active_nxt = vs_fall ? (de_fall ? sat_inc(de_line_cnt) : de_line_cnt) : v_active;

  assign frame_match = (h_total_nxt  == 10'(H_TOTAL_EXP))  &&
                       (v_total_nxt  == 10'(V_TOTAL_EXP))  &&
                       (h_active_nxt == 10'(H_ACTIVE_EXP)) &&
                       (v_active_nxt == 10'(V_ACTIVE_EXP));

  // Line, de, line-per-frame and active-line counters with their latched results.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      line_cnt    <= '0;
      de_cnt      <= '0;
      hs_cnt      <= '0;
      de_line_cnt <= '0;
      h_total     <= '0;
      v_total     <= '0;
      h_active    <= '0;
      v_active    <= '0;
    end else begin
      h_total  <= h_total_nxt;
      h_active <= h_active_nxt;
      v_total  <= v_total_nxt;
      v_active <= v_active_nxt;

      line_cnt <= hs_fall ? 10'd1 : sat_inc(line_cnt);

      if (de_fall)    de_cnt <= '0;
      else if (de_s1) de_cnt <= sat_inc(de_cnt);

      if (vs_fall)      hs_cnt <= '0;
      else if (hs_fall) hs_cnt <= sat_inc(hs_cnt);

      if (vs_fall)      de_line_cnt <= '0;
      else if (de_fall) de_line_cnt <= sat_inc(de_line_cnt);
    end
  end

  assign wd_trip = (wd >= WD_W'(WD_LIMIT));

  // Watchdog on missing hsync; holds at its limit so the trip stays asserted.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix)      wd <= '0;
    else if (hs_fall) wd <= WD_W'(1);
    else if (!wd_trip) wd <= wd + WD_W'(1);
  end

  assign match_inc = match_cnt + MC_W'(1);

  // Lock FSM next state; the watchdog overrides every frame decision.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_nxt = state;
    match_nxt = match_cnt;
    if (wd_trip) begin
      state_nxt = ST_UNLOCKED;
      match_nxt = '0;
    end else if (vs_fall) begin
      case (state)
        ST_UNLOCKED: begin
          state_nxt = ST_CHECK;
          match_nxt = '0;
        end
        ST_CHECK: begin
          if (frame_match) begin
            match_nxt = match_inc;
            if (int'(match_inc) >= LOCK_FRAMES) state_nxt = ST_LOCKED;
          end else begin
            match_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!frame_match) begin
            state_nxt = ST_UNLOCKED;
            match_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_UNLOCKED;
          match_nxt = '0;
        end
      endcase
    end
  end

  // Lock FSM state, match counter and registered lock flag.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state     <= ST_UNLOCKED;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      locked    <= (state_nxt == ST_LOCKED);
    end
  end

  assign vid.sx          = sx;
  assign vid.sy          = sy;
  assign vid.pix_valid   = pix_valid;
  assign vid.line_start  = line_start;
  assign vid.frame_start = frame_start;
  assign vid.h_total     = h_total;
  assign vid.v_total     = v_total;
  assign vid.h_active    = h_active;
  assign vid.v_active    = v_active;
  assign vid.locked      = locked;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder: lock acquisition, pixel coordinates,
// stretched line, missing hsync, mid-line reset and de saturation.
`timescale 1ns/1ps
module tb_video_timing_decoder;

  // Video geometry driven into the decoder (same shape as 640x480, smaller).
  localparam int H_ACT    = 64;
  localparam int HS_START = 72;
  localparam int HS_END   = 84;
  localparam int H_TOT    = 100;
  localparam int V_ACT    = 6;
  localparam int VS_START = 7;
  localparam int VS_END   = 9;
  localparam int V_TOT    = 10;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;

  video_timing_decoder_if vif();

  video_timing_decoder #(
    .H_TOTAL_EXP (H_TOT),
    .V_TOTAL_EXP (V_TOT),
    .H_ACTIVE_EXP(H_ACT),
    .V_ACTIVE_EXP(V_ACT),
    .LOCK_FRAMES (2)
  ) dut (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .vid    (vif)
  );

  always #5 clk_pix = ~clk_pix;

  int n_checks = 0;
  int n_pass   = 0;

  // Position (line, column) of the pixels driven one and two clocks ago.
  int h1y = -1, h1x = -1, h2y = -1, h2x = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all_zero(input string where);
    check({where, ".sx"},          vif.sx,          0);
    check({where, ".sy"},          vif.sy,          0);
    check({where, ".pix_valid"},   vif.pix_valid,   0);
    check({where, ".line_start"},  vif.line_start,  0);
    check({where, ".frame_start"}, vif.frame_start, 0);
    check({where, ".h_total"},     vif.h_total,     0);
    check({where, ".v_total"},     vif.v_total,     0);
    check({where, ".h_active"},    vif.h_active,    0);
    check({where, ".v_active"},    vif.v_active,    0);
    check({where, ".locked"},      vif.locked,      0);
  endtask

  // One frame, lines 0..V_TOT-1. Outputs seen at a falling edge belong to the
  // pixel driven two clocks earlier (h2y, h2x).
  task automatic run_frame(input int  stretch_line, input int nohs_line,
                           input int  rst_line,     input bit chk_pix,
                           input bit  chk_meas,     input int exp_ht,
                           input int  exp_vt,       input bit exp_lock);
    int len;
    bit hs_on;
    for (int y = 0; y < V_TOT; y++) begin
      len = (y == stretch_line) ? H_TOT + 1 : H_TOT;
      for (int x = 0; x < len; x++) begin
        @(negedge clk_pix);
        rst_pix = 1'b0;

        if (h2y == VS_START && h2x == 0) begin
          check("frame_start", vif.frame_start, 1);
          check("locked_at_vs", vif.locked, exp_lock);
          if (chk_meas) begin
            check("h_total",  vif.h_total,  exp_ht);
            check("v_total",  vif.v_total,  exp_vt);
            check("h_active", vif.h_active, H_ACT);
            check("v_active", vif.v_active, V_ACT);
          end
        end
        if (chk_pix) begin
          if (h2y == 0 && h2x == 0) begin
            check("first_px_sx", vif.sx, 0);
            check("first_px_sy", vif.sy, 0);
            check("first_px_valid", vif.pix_valid, 1);
          end
          if (h2y == 0 && h2x == H_ACT - 1) check("last_px_sx", vif.sx, H_ACT - 1);
          if (h2y == 0 && h2x == H_ACT)     check("blank_valid", vif.pix_valid, 0);
          if (h2y == V_ACT - 1 && h2x == 0) check("last_line_sy", vif.sy, V_ACT - 1);
          if (h2y == 1 && h2x == HS_START)     check("line_start_hi", vif.line_start, 1);
          if (h2y == 1 && h2x == HS_START + 1) check("line_start_lo", vif.line_start, 0);
          if (h2y == VS_START && h2x == 1)     check("frame_start_lo", vif.frame_start, 0);
        end
        if (nohs_line >= 0) begin
          if (h2y == nohs_line + 1 && h2x == HS_START - 10) check("wd_still_locked", vif.locked, 1);
          if (h2y == nohs_line + 1 && h2x == HS_START + 5)  check("wd_unlocked", vif.locked, 0);
        end

        hs_on = (x >= HS_START) && (x < HS_END) &&
                !(nohs_line >= 0 && (y == nohs_line || y == nohs_line + 1));
        vif.de    = (y < V_ACT) && (x < H_ACT);
        vif.hsync = !hs_on;
        vif.vsync = !((y >= VS_START) && (y < VS_END));

        h2y = h1y; h2x = h1x;
        h1y = y;   h1x = x;

        if (y == rst_line && x == 30) begin
          #2 rst_pix = 1'b1;
          #1 check_all_zero("async_rst");
        end
      end
    end
  endtask

  initial begin
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.de    = 1'b0;
    repeat (3) @(negedge clk_pix);
    check_all_zero("reset");

    // Lock acquisition: locked appears at the third vs_fall.
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, VS_START, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT,    1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT,    1'b1);
    // Pixel coordinates while locked.
    run_frame(-1, -1, -1, 1'b1, 1'b1, H_TOT, V_TOT,    1'b1);

    // Line before the last pre-vsync line stretched by one clock.
    run_frame(VS_START - 2, -1, -1, 1'b0, 1'b1, H_TOT + 1, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b1);

    // hsync missing on lines 2 and 3: watchdog drops lock.
    run_frame(-1, 2, -1, 1'b0, 1'b1, H_TOT, V_TOT - 2, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b1);

    // Asynchronous reset mid-line while locked.
    run_frame(-1, -1, 2, 1'b0, 1'b0, H_TOT, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b0);
    run_frame(-1, -1, -1, 1'b0, 1'b1, H_TOT, V_TOT, 1'b1);

    // de held high for 2000 clocks: h_active saturates at 1023.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_pix);
      vif.hsync = 1'b1;
      vif.vsync = 1'b1;
      vif.de    = 1'b1;
    end
    check("h_active_hold", vif.h_active, H_ACT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pix);
      vif.de = 1'b0;
    end
    check("h_active_sat", vif.h_active, 1023);
    check("sat_pix_valid", vif.pix_valid, 0);
    check("sat_locked", vif.locked, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
